// File: rtl/vid_frame_sig.sv
// vid_frame_sig: captures one video frame (VS rising edge to VS rising edge)
// and reports a CRC-32 signature over all pixels of complete lines, the line
// count, the shortest/longest line length and a geometry-error flag.
//
// Ports
//   CLK      : sole clock, posedge
//   RES      : synchronous active-high reset
//   CE       : pixel clock enable; DE/VS/RGB are only sampled when CE=1
//   DE, VS   : video data enable / vertical sync (active-high)
//   RGB      : pixel data, DW bits
//   ARM      : level request to capture the next frame
//   BUSY     : armed or capturing
//   DONE     : one-CLK pulse when the result outputs update
//   SIG      : CRC-32 (poly 0x04C11DB7, MSB first, init all-ones, no xorout)
//   LINES    : lines counted in the last frame
//   PIX_MIN  : shortest line (0 when no lines)
//   PIX_MAX  : longest line
//   GEOM_ERR : last frame differs from EXP_W x EXP_H
module vid_frame_sig #(
  parameter int DW    = 24,
  parameter int PW    = 9,
  parameter int LW    = 9,
  parameter int EXP_W = 256,
  parameter int EXP_H = 222,
  parameter int CONT  = 0
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          CE,
  input  logic          DE,
  input  logic          VS,
  input  logic [DW-1:0] RGB,
  input  logic          ARM,
  output logic          BUSY,
  output logic          DONE,
  output logic [31:0]   SIG,
  output logic [LW-1:0] LINES,
  output logic [PW-1:0] PIX_MIN,
  output logic [PW-1:0] PIX_MAX,
  output logic          GEOM_ERR
);

  localparam logic [31:0]   POLY    = 32'h04C11DB7;
  localparam logic [LW-1:0] EXP_H_L = LW'(EXP_H);
  localparam logic [PW-1:0] EXP_W_L = PW'(EXP_W);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

  state_t        state, state_nxt;
  logic          prev_de, prev_vs, line_open;
  logic [31:0]   crc;
  logic [PW-1:0] pix, pmin, pmax;
  logic [LW-1:0] lines;

  logic          de_rise, de_fall, vs_rise, open_eff, take, close_line, open_nxt;
  logic          start_frame, end_frame;
  logic [31:0]   crc_cur;
  logic [PW-1:0] pix_base, pix_cur, min_cur, max_cur, rep_min;
  logic [LW-1:0] lines_cur;

  function automatic logic [31:0] crc_fold(input logic [31:0] c, input logic [DW-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = DW - 1; i >= 0; i--)
      r = {r[30:0], 1'b0} ^ (((r[31] ^ d[i]) != 1'b0) ? POLY : 32'h0);
    return r;
  endfunction

  function automatic logic [PW-1:0] sat_inc_pix(input logic [PW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [LW-1:0] sat_inc_line(input logic [LW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign BUSY = (state != IDLE);

  // Per-CE capture step. A line opened by this very DE rising edge already
  // counts its first pixel, and a VS edge landing while DE is high closes the
  // line including the pixel sampled on that edge.
  always_comb begin
    de_rise    = CE & DE & ~prev_de;
    de_fall    = CE & ~DE & prev_de;
    vs_rise    = CE & VS & ~prev_vs;
    open_eff   = line_open | de_rise;
    pix_base   = de_rise ? '0 : pix;
    take       = CE & DE & open_eff;
    crc_cur    = take ? crc_fold(crc, RGB) : crc;
    pix_cur    = take ? sat_inc_pix(pix_base) : pix_base;
    close_line = (de_fall & line_open) | (vs_rise & DE & open_eff);
    lines_cur  = close_line ? sat_inc_line(lines) : lines;
    min_cur    = (close_line && pix_cur < pmin) ? pix_cur : pmin;
    max_cur    = (close_line && pix_cur > pmax) ? pix_cur : pmax;
    open_nxt   = CE ? (DE & open_eff & ~close_line) : line_open;
    rep_min    = (lines_cur == '0) ? '0 : min_cur;
  end

  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE:    if (ARM) state_nxt = WAIT_VS;
      WAIT_VS: if (vs_rise) begin
        state_nxt   = CAPTURE;
        start_frame = 1'b1;
      end
      CAPTURE: if (vs_rise) begin
        end_frame = 1'b1;
        // In continuous mode the ending VS edge also opens the next frame.
        if (CONT != 0 && ARM) begin
          state_nxt   = CAPTURE;
          start_frame = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      prev_de   <= 1'b0;
      prev_vs   <= 1'b0;
      line_open <= 1'b0;
      DONE      <= 1'b0;
      SIG       <= '0;
      LINES     <= '0;
      PIX_MIN   <= '0;
      PIX_MAX   <= '0;
      GEOM_ERR  <= 1'b0;
    end else begin
      DONE <= end_frame;
      if (CE) begin
        prev_de <= DE;
        prev_vs <= VS;
      end
      if (end_frame) begin
        SIG      <= crc_cur;
        LINES    <= lines_cur;
        PIX_MIN  <= rep_min;
        PIX_MAX  <= max_cur;
        GEOM_ERR <= (lines_cur != EXP_H_L) | (rep_min != EXP_W_L) | (max_cur != EXP_W_L);
      end
      if (start_frame)                   line_open <= 1'b0;
      else if (state == CAPTURE && CE)   line_open <= open_nxt;
    end
  end

  // Accumulators need no reset: every capture starts by re-initialising them.
  always_ff @(posedge CLK) begin
    if (start_frame) begin
      crc   <= 32'hFFFF_FFFF;
      pix   <= '0;
      lines <= '0;
      pmin  <= '1;
      pmax  <= '0;
    end else if (state == CAPTURE && CE) begin
      crc   <= crc_cur;
      pix   <= pix_cur;
      lines <= lines_cur;
      pmin  <= min_cur;
      pmax  <= max_cur;
    end
  end

endmodule

// File: tb/tb_vid_frame_sig.sv
module tb_vid_frame_sig;
  localparam int DW = 24;
  localparam int PW = 9;
  localparam int LW = 9;

  logic clk = 1'b0;
  logic res, ce, de, vs, arm, arm_c;
  logic [DW-1:0] rgb;
  logic busy, done, geom, busy_c, done_c, geom_c;
  logic [31:0] sig, sig_c;
  logic [LW-1:0] lines, lines_c;
  logic [PW-1:0] pmin, pmax, pmin_c, pmax_c;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_done_c = 0;
  logic [31:0] mcrc;
  logic [31:0] ref_sig;

  vid_frame_sig #(.DW(DW), .PW(PW), .LW(LW), .EXP_W(4), .EXP_H(3), .CONT(0)) u_dut (
    .CLK(clk), .RES(res), .CE(ce), .DE(de), .VS(vs), .RGB(rgb), .ARM(arm),
    .BUSY(busy), .DONE(done), .SIG(sig), .LINES(lines), .PIX_MIN(pmin),
    .PIX_MAX(pmax), .GEOM_ERR(geom));

  vid_frame_sig #(.DW(DW), .PW(PW), .LW(LW), .EXP_W(4), .EXP_H(3), .CONT(1)) u_cont (
    .CLK(clk), .RES(res), .CE(ce), .DE(de), .VS(vs), .RGB(rgb), .ARM(arm_c),
    .BUSY(busy_c), .DONE(done_c), .SIG(sig_c), .LINES(lines_c), .PIX_MIN(pmin_c),
    .PIX_MAX(pmax_c), .GEOM_ERR(geom_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] name;
    int          nl;
    int          len0, len1, len2;
    int          mode;      // 0 constant, 1 one pixel bit0 flipped, 2 ASCII "123456789"
    int          e_lines, e_min, e_max;
    logic        e_geom;
    logic        chk_const;
    logic [31:0] e_sig;
    int          rel;       // 0 none, 1 save as reference, 2 equal reference, 3 differ from reference
  } frame_t;

  frame_t tbl[6];

  // Straight bit-serial long division of the pixel stream.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [23:0] w);
    logic [31:0] r;
    logic        msb;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      msb = r[31];
      r   = r << 1;
      if (msb != w[i]) r = r ^ 32'h04C11DB7;
    end
    return r;
  endfunction

  function automatic logic [23:0] pixval(input int mode, input int idx);
    logic [23:0] v;
    v = 24'h123456;
    if (mode == 1 && idx == 5) v = 24'h123457;
    if (mode == 2) v = (idx == 0) ? 24'h313233 : (idx == 1) ? 24'h343536 : 24'h373839;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic ce_i, input logic de_i, input logic vs_i, input logic [23:0] rgb_i);
    ce = ce_i; de = de_i; vs = vs_i; rgb = rgb_i;
    @(posedge clk);
    #1;
    if (done)   n_done++;
    if (done_c) n_done_c++;
  endtask

  task automatic line(input int len, input logic [23:0] base);
    logic [23:0] v;
    for (int p = 0; p < len; p++) begin
      v = base + 24'(p);
      mcrc = crc_model(mcrc, v);
      step(1'b1, 1'b1, 1'b0, v);
    end
    step(1'b1, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic arm_dut();
    arm = 1'b1;
    step(1'b0, 1'b0, 1'b0, 24'h0);
    arm = 1'b0;
    chk("armed_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_frame(input frame_t f);
    int          pidx;
    int          len;
    logic [23:0] v;
    string       nm;
    nm = $sformatf("%0s", f.name);
    arm_dut();
    n_done = 0;
    step(1'b1, 1'b0, 1'b1, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    mcrc = 32'hFFFF_FFFF;
    pidx = 0;
    for (int l = 0; l < f.nl; l++) begin
      len = (l == 0) ? f.len0 : (l == 1) ? f.len1 : f.len2;
      for (int p = 0; p < len; p++) begin
        v = pixval(f.mode, pidx);
        mcrc = crc_model(mcrc, v);
        step(1'b1, 1'b1, 1'b0, v);
        pidx++;
      end
      step(1'b1, 1'b0, 1'b0, 24'h0);
      step(1'b1, 1'b0, 1'b0, 24'h0);
    end
    chk({nm, "_early_done"}, 32'(n_done), 32'd0);
    step(1'b1, 1'b0, 1'b1, 24'h0);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_sig_model"}, sig, mcrc);
    if (f.chk_const) chk({nm, "_sig_const"}, sig, f.e_sig);
    chk({nm, "_lines"}, 32'(lines), 32'(f.e_lines));
    chk({nm, "_min"}, 32'(pmin), 32'(f.e_min));
    chk({nm, "_max"}, 32'(pmax), 32'(f.e_max));
    chk({nm, "_geom"}, 32'(geom), 32'(f.e_geom));
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    if (f.rel == 1) ref_sig = sig;
    if (f.rel == 2) chk({nm, "_sig_eq_ref"}, sig, ref_sig);
    if (f.rel == 3) begin
      checks++;
      if (sig === ref_sig) begin
        errors++;
        $display("FAIL %s_sig_ne_ref got %h want value other than %h", nm, sig, ref_sig);
      end
    end
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_done_count"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    tbl[0] = '{"empty",  0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFF, 0};
    tbl[1] = '{"short",  3, 4, 4, 3, 0, 3, 3, 4, 1'b1, 1'b0, 32'h0,         0};
    tbl[2] = '{"exact",  3, 4, 4, 4, 0, 3, 4, 4, 1'b0, 1'b0, 32'h0,         1};
    tbl[3] = '{"repeat", 3, 4, 4, 4, 0, 3, 4, 4, 1'b0, 1'b0, 32'h0,         2};
    tbl[4] = '{"flip",   3, 4, 4, 4, 1, 3, 4, 4, 1'b0, 1'b0, 32'h0,         3};
    tbl[5] = '{"ascii",  1, 3, 0, 0, 2, 1, 3, 3, 1'b1, 1'b1, 32'h0376_E6E7, 0};

    res = 1'b1; ce = 1'b0; de = 1'b0; vs = 1'b0; rgb = '0; arm = 1'b0; arm_c = 1'b0;
    ref_sig = '0; mcrc = '0;
    step(1'b0, 1'b0, 1'b0, 24'h0);
    step(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    res = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sig", sig, 32'h0);
    chk("rst_lines", 32'(lines), 32'd0);
    chk("rst_min", 32'(pmin), 32'd0);
    chk("rst_max", 32'(pmax), 32'd0);
    chk("rst_geom", 32'(geom), 32'd0);
    chk("rst_busy_c", 32'(busy_c), 32'd0);
    step(1'b1, 1'b0, 1'b0, 24'h0);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // DE already high at the starting VS edge; DE still high at the ending one.
    arm_dut();
    n_done = 0;
    step(1'b1, 1'b1, 1'b0, 24'hAAAAAA);
    step(1'b1, 1'b1, 1'b1, 24'hBBBBBB);
    mcrc = 32'hFFFF_FFFF;
    step(1'b1, 1'b1, 1'b0, 24'hCCCCCC);
    step(1'b1, 1'b1, 1'b0, 24'hDDDDDD);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    line(4, 24'h100000);
    line(4, 24'h200000);
    for (int p = 0; p < 3; p++) begin
      mcrc = crc_model(mcrc, 24'h300000 + 24'(p));
      step(1'b1, 1'b1, 1'b0, 24'h300000 + 24'(p));
    end
    mcrc = crc_model(mcrc, 24'h300003);
    step(1'b1, 1'b1, 1'b1, 24'h300003);
    chk("de_edge_done", 32'(done), 32'd1);
    chk("de_edge_lines", 32'(lines), 32'd3);
    chk("de_edge_min", 32'(pmin), 32'd4);
    chk("de_edge_max", 32'(pmax), 32'd4);
    chk("de_edge_geom", 32'(geom), 32'd0);
    chk("de_edge_sig", sig, mcrc);
    step(1'b1, 1'b0, 1'b0, 24'h0);

    // CE held low for 5 CLKs mid-line with DE/VS/RGB wiggling.
    arm_dut();
    n_done = 0;
    step(1'b1, 1'b0, 1'b1, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    mcrc = 32'hFFFF_FFFF;
    for (int p = 0; p < 2; p++) begin
      mcrc = crc_model(mcrc, 24'h400000 + 24'(p));
      step(1'b1, 1'b1, 1'b0, 24'h400000 + 24'(p));
    end
    for (int k = 0; k < 5; k++) step(1'b0, k[0], 1'b1, 24'hFFFFFF);
    chk("ce_hold_busy", 32'(busy), 32'd1);
    chk("ce_hold_no_done", 32'(n_done), 32'd0);
    for (int p = 2; p < 4; p++) begin
      mcrc = crc_model(mcrc, 24'h400000 + 24'(p));
      step(1'b1, 1'b1, 1'b0, 24'h400000 + 24'(p));
    end
    step(1'b1, 1'b0, 1'b0, 24'h0);
    line(4, 24'h500000);
    line(4, 24'h600000);
    step(1'b1, 1'b0, 1'b1, 24'h0);
    chk("ce_hold_lines", 32'(lines), 32'd3);
    chk("ce_hold_min", 32'(pmin), 32'd4);
    chk("ce_hold_max", 32'(pmax), 32'd4);
    chk("ce_hold_geom", 32'(geom), 32'd0);
    chk("ce_hold_sig", sig, mcrc);
    step(1'b1, 1'b0, 1'b0, 24'h0);

    // Reset in the middle of a capture.
    arm_dut();
    step(1'b1, 1'b0, 1'b1, 24'h0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    line(4, 24'h700000);
    step(1'b1, 1'b1, 1'b0, 24'h777777);
    n_done = 0;
    res = 1'b1;
    step(1'b1, 1'b1, 1'b0, 24'h777777);
    res = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sig", sig, 32'h0);
    chk("abort_lines", 32'(lines), 32'd0);
    chk("abort_min", 32'(pmin), 32'd0);
    chk("abort_max", 32'(pmax), 32'd0);
    chk("abort_geom", 32'(geom), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b0, 1'b1, 24'h0);
      step(1'b1, 1'b0, 1'b0, 24'h0);
    end
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    // Continuous capture with ARM held high.
    arm_c = 1'b1;
    step(1'b0, 1'b0, 1'b0, 24'h0);
    n_done_c = 0;
    step(1'b1, 1'b0, 1'b1, 24'h0);
    chk("cont_edge1_done", 32'(done_c), 32'd0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    mcrc = 32'hFFFF_FFFF;
    line(4, 24'h800000);
    step(1'b1, 1'b0, 1'b1, 24'h0);
    chk("cont_edge2_done", 32'(done_c), 32'd1);
    chk("cont_edge2_lines", 32'(lines_c), 32'd1);
    chk("cont_edge2_sig", sig_c, mcrc);
    chk("cont_edge2_busy", 32'(busy_c), 32'd1);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    mcrc = 32'hFFFF_FFFF;
    line(4, 24'h900000);
    line(4, 24'hA00000);
    step(1'b1, 1'b0, 1'b1, 24'h0);
    chk("cont_edge3_done", 32'(done_c), 32'd1);
    chk("cont_edge3_lines", 32'(lines_c), 32'd2);
    chk("cont_edge3_min", 32'(pmin_c), 32'd4);
    chk("cont_edge3_sig", sig_c, mcrc);
    chk("cont_edge3_busy", 32'(busy_c), 32'd1);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("cont_done_pulse", 32'(done_c), 32'd0);
    arm_c = 1'b0;
    line(4, 24'hB00000);
    step(1'b1, 1'b0, 1'b1, 24'h0);
    chk("cont_stop_done", 32'(done_c), 32'd1);
    chk("cont_stop_lines", 32'(lines_c), 32'd1);
    chk("cont_stop_busy", 32'(busy_c), 32'd0);
    step(1'b1, 1'b0, 1'b0, 24'h0);
    chk("cont_done_count", 32'(n_done_c), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
